// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: ImmSrc codes,
// the FIFO entry layout and the immediate range helper.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immSrc_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } fifoEntry_t;

  // True when imm[31:lsb] are all equal, i.e. the value fits the signed field.
  function automatic logic immFits(input logic [31:0] imm, input int unsigned lsb);
    logic [31:0] shifted;
    shifted = 32'($signed(imm) >>> lsb);
    return (shifted == 32'h0000_0000) || (shifted == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle between an instruction source/consumer and the encoder.
interface instr_encoder_if;
  import instr_encoder_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ImmSrc;
  logic [6:0]  Op;
  logic [2:0]  Funct3;
  logic [4:0]  Rd;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic [31:0] Imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  modport master (
    output in_valid, ImmSrc, Op, Funct3, Rd, Rs1, Rs2, Imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );

  modport slave (
    input  in_valid, ImmSrc, Op, Funct3, Rd, Rs1, Rs2, Imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );
endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Combinational packer: scatters the immediate into the I/S/B/J bit slots
// and flags immediates that do not fit or are misaligned for the format.
module imm_pack
  import instr_encoder_pkg::*;
(
  input  logic [1:0]  ImmSrc,
  input  logic [6:0]  Op,
  input  logic [2:0]  Funct3,
  input  logic [4:0]  Rd,
  input  logic [4:0]  Rs1,
  input  logic [4:0]  Rs2,
  input  logic [31:0] Imm,
  output logic [31:0] instr,
  output logic        err
);

  // Format-specific field placement and range/alignment check.
  always_comb begin
    instr = 32'h0000_0000;
    err   = 1'b0;
    case (immSrc_t'(ImmSrc))
      IMM_I: begin
        instr = {Imm[11:0], Rs1, Funct3, Rd, Op};
        err   = !immFits(Imm, 11);
      end
      IMM_S: begin
        instr = {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], Op};
        err   = !immFits(Imm, 11);
      end
      IMM_B: begin
        instr = {Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], Op};
        err   = !immFits(Imm, 12) || Imm[0];
      end
      IMM_J: begin
        instr = {Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, Op};
        err   = !immFits(Imm, 20) || Imm[0];
      end
      default: begin
        instr = 32'h0000_0000;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder top: encodes accepted requests into an output FIFO,
// tagging each word with its byte address and a range-error flag.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic            clk,
  input logic            reset,
  input logic            flush,
  instr_encoder_if.slave bus
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);

  fifoEntry_t    mem_r [DEPTH];
  logic [PW-1:0] wrPtr_r;
  logic [PW-1:0] rdPtr_r;
  logic [PW:0]   count_r;
  logic [31:0]   addr_r;
  logic [7:0]    errCount_r;

  logic [31:0]   encInstr_s;
  logic          encErr_s;
  logic          push_s;
  logic          pop_s;
  logic          empty_s;

  imm_pack u_pack (
    .ImmSrc (bus.ImmSrc),
    .Op     (bus.Op),
    .Funct3 (bus.Funct3),
    .Rd     (bus.Rd),
    .Rs1    (bus.Rs1),
    .Rs2    (bus.Rs2),
    .Imm    (bus.Imm),
    .instr  (encInstr_s),
    .err    (encErr_s)
  );

  assign empty_s       = (count_r == (PW+1)'(0));
  assign bus.in_ready  = (count_r < DEPTH_C);
  assign bus.out_valid = !empty_s;
  // Flush discards any handshake that coincides with it.
  assign push_s        = bus.in_valid && bus.in_ready && !flush;
  assign pop_s         = bus.out_valid && bus.out_ready && !flush;

  assign bus.out_instr = empty_s ? 32'h0000_0000 : mem_r[rdPtr_r].instr;
  assign bus.out_addr  = empty_s ? 32'h0000_0000 : mem_r[rdPtr_r].addr;
  assign bus.out_err   = empty_s ? 1'b0          : mem_r[rdPtr_r].err;
  assign bus.err_count = errCount_r;

  // FIFO storage, pointers, occupancy, address counter and error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wrPtr_r    <= '0;
      rdPtr_r    <= '0;
      count_r    <= '0;
      addr_r     <= BASE_ADDR;
      errCount_r <= 8'h00;
    end else if (flush) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      count_r <= '0;
      addr_r  <= BASE_ADDR;
    end else begin
      if (push_s) begin
        mem_r[wrPtr_r] <= '{instr: encInstr_s, addr: addr_r, err: encErr_s};
        wrPtr_r        <= wrPtr_r + PW'(1);
        addr_r         <= addr_r + 32'd4;
        if (encErr_s && (errCount_r != 8'hFF)) begin
          errCount_r <= errCount_r + 8'd1;
        end
      end
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors push expected words,
// a negedge monitor pops and compares every word the DUT hands out.
module tb_instr_encoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  instr_encoder_if bus ();

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] expAddr = 32'h0;
  int          expErrCnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every word the consumer takes must match the queue head.
  always @(negedge clk) begin
    if (!reset && !flush && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got=%h expected=none", bus.out_instr);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_instr", bus.out_instr, e.instr);
        chk("out_addr", bus.out_addr, e.addr);
        chk("out_err", {31'h0, bus.out_err}, {31'h0, e.err});
      end
    end
  end

  task automatic drive(input logic [1:0] src, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    bus.in_valid = 1'b1;
    bus.ImmSrc = src; bus.Op = op; bus.Funct3 = f3;
    bus.Rd = rd; bus.Rs1 = rs1; bus.Rs2 = rs2; bus.Imm = imm;
  endtask

  task automatic send(input logic [1:0] src, input logic [6:0] op, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] expInstr, input logic expErr);
    int n = 0;
    drive(src, op, f3, rd, rs1, rs2, imm);
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got=in_ready 0 expected=1");
    end else begin
      q.push_back('{instr: expInstr, addr: expAddr, err: expErr});
      expAddr = expAddr + 32'd4;
      if (expErr && expErrCnt < 255) expErrCnt++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", q.size(), 0);
    @(posedge clk); #1;
    chk("drained_valid", {31'h0, bus.out_valid}, 32'h0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.ImmSrc = 2'b00; bus.Op = 7'h00; bus.Funct3 = 3'h0;
    bus.Rd = 5'h00; bus.Rs1 = 5'h00; bus.Rs2 = 5'h00; bus.Imm = 32'h0;
    #1 reset = 1'b1;
    #1;
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_err_count", {24'h0, bus.err_count}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic I/S/B/J encodings.
    bus.out_ready = 1'b1;
    send(2'b00, 7'b0010011, 3'b000, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0293, 1'b0);
    send(2'b01, 7'b0100011, 3'b010, 5'd0, 5'd2, 5'd6, 32'h0000_0008, 32'h0061_2423, 1'b0);
    send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
    send(2'b11, 7'b1101111, 3'b000, 5'd1, 5'd0, 5'd0, 32'h0000_0008, 32'h0080_00EF, 1'b0);
    drain();
    chk("err_count_clean", {24'h0, bus.err_count}, 32'h0);

    // Range and alignment errors.
    send(2'b00, 7'b0010011, 3'b000, 5'd5, 5'd0, 5'd0, 32'h0000_0800, 32'h8000_0293, 1'b1);
    chk("err_count_1", {24'h0, bus.err_count}, 32'h1);
    send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'h0000_0003, 32'h0020_8163, 1'b1);
    chk("err_count_2", {24'h0, bus.err_count}, 32'h2);
    for (int i = 0; i < 300; i++) begin
      send(2'b00, 7'b0010011, 3'b000, 5'd5, 5'd0, 5'd0, 32'h0000_0800, 32'h8000_0293, 1'b1);
    end
    drain();
    chk("err_count_sat", {24'h0, bus.err_count}, 32'd255);
    chk("err_count_model", 32'(expErrCnt), 32'd255);

    // Restart addresses, then fill the FIFO under backpressure.
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    expAddr = 32'h0;
    bus.out_ready = 1'b0;
    send(2'b00, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
    send(2'b00, 7'b0010011, 3'b000, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0113, 1'b0);
    send(2'b00, 7'b0010011, 3'b000, 5'd3, 5'd0, 5'd0, 32'd3, 32'h0030_0193, 1'b0);
    send(2'b00, 7'b0010011, 3'b000, 5'd4, 5'd0, 5'd0, 32'd4, 32'h0040_0213, 1'b0);
    drive(2'b00, 7'b0010011, 3'b000, 5'd5, 5'd0, 5'd0, 32'd5);
    chk("full_in_ready", {31'h0, bus.in_ready}, 32'h0);
    chk("full_head_addr", bus.out_addr, 32'h0);
    bus.out_ready = 1'b1;
    send(2'b00, 7'b0010011, 3'b000, 5'd5, 5'd0, 5'd0, 32'd5, 32'h0050_0293, 1'b0);
    drain();

    // Simultaneous push and pop at count 2 leaves count at 2.
    bus.out_ready = 1'b0;
    send(2'b00, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
    send(2'b00, 7'b0010011, 3'b000, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0113, 1'b0);
    bus.out_ready = 1'b1;
    send(2'b00, 7'b0010011, 3'b000, 5'd3, 5'd0, 5'd0, 32'd3, 32'h0030_0193, 1'b0);
    bus.out_ready = 1'b0;
    send(2'b00, 7'b0010011, 3'b000, 5'd4, 5'd0, 5'd0, 32'd4, 32'h0040_0213, 1'b0);
    chk("pp_not_full", {31'h0, bus.in_ready}, 32'h1);
    send(2'b00, 7'b0010011, 3'b000, 5'd5, 5'd0, 5'd0, 32'd5, 32'h0050_0293, 1'b0);
    chk("pp_full", {31'h0, bus.in_ready}, 32'h0);
    bus.out_ready = 1'b1;
    drain();

    // Flush with entries queued and a request offered in the same cycle.
    bus.out_ready = 1'b0;
    send(2'b00, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
    send(2'b00, 7'b0010011, 3'b000, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0113, 1'b0);
    send(2'b00, 7'b0010011, 3'b000, 5'd3, 5'd0, 5'd0, 32'd3, 32'h0030_0193, 1'b0);
    drive(2'b00, 7'b0010011, 3'b000, 5'd7, 5'd0, 5'd0, 32'd7);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    expAddr = 32'h0;
    chk("flush_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("flush_out_instr", bus.out_instr, 32'h0);
    chk("flush_in_ready", {31'h0, bus.in_ready}, 32'h1);
    chk("flush_keeps_err", {24'h0, bus.err_count}, 32'd255);
    bus.out_ready = 1'b1;
    send(2'b11, 7'b1101111, 3'b000, 5'd1, 5'd0, 5'd0, 32'h0000_0008, 32'h0080_00EF, 1'b0);
    drain();

    // Asynchronous reset between edges in the middle of a burst.
    bus.out_ready = 1'b0;
    send(2'b00, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
    send(2'b00, 7'b0010011, 3'b000, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0113, 1'b0);
    drive(2'b00, 7'b0010011, 3'b000, 5'd3, 5'd0, 5'd0, 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("arst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    chk("arst_err_count", {24'h0, bus.err_count}, 32'h0);
    bus.in_valid = 1'b0;
    q.delete();
    expAddr = 32'h0;
    expErrCnt = 0;
    #1 reset = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(2'b01, 7'b0100011, 3'b010, 5'd0, 5'd2, 5'd6, 32'h0000_0008, 32'h0061_2423, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate generator: packs opcode, register fields and a 32-bit signed immediate into a 32-bit RV32I instruction word for the ImmSrc formats I/S/B/J.
- Used by the instruction-memory loader and self-test sequencer to build program images.
- Valid/ready input, output FIFO, per-instruction byte address, and range-error detection with a saturating error counter.

Parameters:
DEPTH, 4, output FIFO entries; power of two, >=2
BASE_ADDR, 32'h0000_0000, address assigned to the first instruction after reset or flush

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous; empty FIFO, reload address counter
in_valid  input  1  request valid
in_ready  output  1  encoder can accept
ImmSrc  input  2  00 I, 01 S, 10 B, 11 J
Op  input  7  opcode, placed in instr[6:0]
Funct3  input  3  instr[14:12] (I/S/B only)
Rd  input  5  instr[11:7] (I/J only)
Rs1  input  5  instr[19:15] (I/S/B only)
Rs2  input  5  instr[24:20] (S/B only)
Imm  input  32  signed immediate, byte offset
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer takes head
out_instr  output  32  encoded word at head
out_addr  output  32  byte address of head word
out_err  output  1  head immediate was out of range or misaligned
err_count  output  8  saturating count of accepted erroneous requests

Behaviour:
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count < DEPTH). No push-through when full.
- Push and pop in the same cycle: count unchanged.
- Encoding is combinational at the FIFO write port.
- Latency: a request accepted at edge N appears at the head after edge N if the FIFO was empty; otherwise it appears in order.
- out_instr/out_addr/out_err are registered FIFO contents. They read 0 when empty.
- Field packing:
  - I: [31:20]=Imm[11:0]
  - S: [31:25]=Imm[11:5], [11:7]=Imm[4:0]
  - B: [31]=Imm[12], [30:25]=Imm[10:5], [11:8]=Imm[4:1], [7]=Imm[11]
  - J: [31]=Imm[20], [30:21]=Imm[10:1], [20]=Imm[11], [19:12]=Imm[19:12]
  - Fields unused by a format come from the immediate, never from Rd/Rs/Funct3.
- Error flag (stored per entry):
  - I/S: Imm[31:11] not all equal.
  - B: Imm[31:12] not all equal, or Imm[0]=1.
  - J: Imm[31:20] not all equal, or Imm[0]=1.
  - An erroneous request is still encoded with truncated bits and still consumes an address.
- Address counter: starts at BASE_ADDR and adds 4 per accepted request. Wraps modulo 2^32 without a flag. The current value is stored into the entry on push.
- err_count increments on each accepted erroneous request and saturates at 255. Not cleared by flush.
- flush:
  - Next edge: count=0, pointers=0, address counter=BASE_ADDR.
  - A push or pop in the flush cycle is discarded.
  - in_ready stays as computed that cycle, but the accept is dropped; the source must not rely on it.
- reset (asynchronous, mid-operation included): count, pointers, err_count = 0; address counter = BASE_ADDR. in_ready=1 and out_valid=0 immediately.
- No X propagation: out_* driven to 0 when empty.

Decomposition:
- Shared package: ImmSrc constants (IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_J=2'b11), shared with the sign-extend/control decoder.
- Sub-module imm_pack (combinational): ImmSrc, fields, Imm -> instr, err.
- The top holds the FIFO, counters and handshake.

Test Plan:
- I: Op=0010011, F3=000, Rd=5, Rs1=0, Imm=FFFFFFFF -> out_instr=FFF00293, out_addr=0, out_err=0.
- S: Op=0100011, F3=010, Rs1=2, Rs2=6, Imm=8 -> 00612423, out_addr=4. B: Op=1100011, F3=000, Rs1=1, Rs2=2, Imm=FFFFFFFC -> FE208EE3, out_addr=8. J: Op=1101111, Rd=1, Imm=8 -> 008000EF, out_addr=12.
- Range/alignment: I with Imm=00000800 -> out_instr=80000293, out_err=1, err_count=1. B with Imm=3 -> out_err=1, err_count=2. 300 erroneous requests -> err_count=255.
- Backpressure, DEPTH=4: out_ready=0, offer 5 requests -> in_ready=0 after 4 accepts. Release out_ready -> 4 words pop in order at addrs 0,4,8,12, then the 5th enters at addr 16. Simultaneous push/pop at full is not possible; at count 2, push+pop keeps count 2.
- flush with 3 entries queued and in_valid=1 -> next cycle out_valid=0, flush-cycle request dropped, next accepted request gets addr=BASE_ADDR.
- Asynchronous reset asserted mid-burst between edges -> out_valid=0 and in_ready=1 before the next edge, err_count=0, first post-reset request gets addr=BASE_ADDR.
